// File: rtl/rate_digit_counter_pkg.sv
// Shared constants for the rate-divided multi-digit counter: digit geometry,
// digit limits, seven-segment glyphs (active-low, bits g..a) and rate selects.
package rate_counter_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   localparam logic [DIGIT_W-1:0] HEX_MAX = 4'hF;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
   localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
   localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
   localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
   localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
   localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
   localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
   localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

   typedef enum logic [1:0] {
      RATE_SEL_0 = 2'd0,
      RATE_SEL_1 = 2'd1,
      RATE_SEL_2 = 2'd2,
      RATE_SEL_3 = 2'd3
   } rate_sel_e;

endpackage

// File: rtl/rate_digit_counter_if.sv
// Control/status bundle of the rate digit counter; master drives controls,
// slave (the counter) drives count, strobes and segments.
interface rate_digit_counter_if #(
   parameter int DIGITS = 4
);
   import rate_counter_pkg::*;

   logic [1:0]                 rate_sel;
   logic                       enable;
   logic                       up;
   logic                       bcd;
   logic                       load;
   logic [DIGIT_W*DIGITS-1:0]  load_value;
   logic [DIGIT_W*DIGITS-1:0]  count;
   logic                       tick;
   logic                       wrap;
   logic [SEG_W*DIGITS-1:0]    hex;

   modport master (
      output rate_sel, enable, up, bcd, load, load_value,
      input  count, tick, wrap, hex
   );

   modport slave (
      input  rate_sel, enable, up, bcd, load, load_value,
      output count, tick, wrap, hex
   );

endinterface

// File: rtl/rate_digit_counter_decoder.sv
// Combinational 4-bit to active-low seven-segment decoder (bit0=a .. bit6=g).
module hex_digit_decoder
   import rate_counter_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg
);

   always_comb begin
      case (digit)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/rate_digit_counter.sv
// Multi-digit up/down BCD/hex counter advanced by a programmable rate divider,
// with parallel load, pause, tick/wrap strobes and per-digit segment decoders.
module rate_digit_counter
   import rate_counter_pkg::*;
#(
   parameter int          DIGITS = 4,
   parameter int          DIV_W  = 28,
   parameter int unsigned RATE_0 = 0,
   parameter int unsigned RATE_1 = 49_999_999,
   parameter int unsigned RATE_2 = 99_999_999,
   parameter int unsigned RATE_3 = 199_999_999
) (
   input  logic               clock,
   input  logic               reset,
   rate_digit_counter_if.slave bus
);

   localparam int CNT_W = DIGIT_W * DIGITS;

   logic [CNT_W-1:0] count_q, count_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] stepped;
   logic             step_wrap;
   wire  [SEG_W*DIGITS-1:0] hex_w;

   function automatic logic [DIV_W-1:0] rate_of(input logic [1:0] sel);
      case (rate_sel_e'(sel))
         RATE_SEL_0: rate_of = DIV_W'(RATE_0);
         RATE_SEL_1: rate_of = DIV_W'(RATE_1);
         RATE_SEL_2: rate_of = DIV_W'(RATE_2);
         default:    rate_of = DIV_W'(RATE_3);
      endcase
   endfunction

   // Ripple one step through the digits; the MSB of the result is the carry
   // or borrow that left the top digit.
   function automatic logic [CNT_W:0] step_count(input logic [CNT_W-1:0] cnt,
                                                 input logic up_i, input logic bcd_i);
      logic [CNT_W-1:0]   res;
      logic [DIGIT_W-1:0] dig;
      logic [DIGIT_W-1:0] max_v;
      logic               carry;
      res   = cnt;
      carry = 1'b1;
      max_v = bcd_i ? BCD_MAX : HEX_MAX;
      for (int k = 0; k < DIGITS; k++) begin
         dig = cnt[k*DIGIT_W +: DIGIT_W];
         if (carry) begin
            if (up_i) begin
               // Out-of-range BCD digits also roll to 0 with carry.
               if (dig >= max_v) begin
                  dig = '0;
               end else begin
                  dig   = dig + 1'b1;
                  carry = 1'b0;
               end
            end else if (dig == '0) begin
               dig = max_v;
            end else if (dig > max_v) begin
               dig   = max_v;
               carry = 1'b0;
            end else begin
               dig   = dig - 1'b1;
               carry = 1'b0;
            end
         end
         res[k*DIGIT_W +: DIGIT_W] = dig;
      end
      step_count = {carry, res};
   endfunction

   assign {step_wrap, stepped} = step_count(count_q, bus.up, bus.bcd);

   always_comb begin
      count_d   = count_q;
      div_cnt_d = div_cnt_q;
      sel_d     = sel_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      if (bus.load) begin
         count_d   = bus.load_value;
         div_cnt_d = rate_of(bus.rate_sel);
      end else if (bus.rate_sel != sel_q) begin
         div_cnt_d = rate_of(bus.rate_sel);
         sel_d     = bus.rate_sel;
      end else if (bus.enable) begin
         if (div_cnt_q != '0) begin
            div_cnt_d = div_cnt_q - 1'b1;
         end else begin
            div_cnt_d = rate_of(sel_q);
            tick_d    = 1'b1;
            wrap_d    = step_wrap;
            count_d   = stepped;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q   <= '0;
         div_cnt_q <= rate_of(bus.rate_sel);
         sel_q     <= bus.rate_sel;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         count_q   <= count_d;
         div_cnt_q <= div_cnt_d;
         sel_q     <= sel_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      hex_digit_decoder u_dec (
         .digit (count_q[g*DIGIT_W +: DIGIT_W]),
         .seg   (hex_w[g*SEG_W +: SEG_W])
      );
   end

   assign bus.count = count_q;
   assign bus.tick  = tick_q;
   assign bus.wrap  = wrap_q;
   assign bus.hex   = hex_w;

endmodule
